// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard controller.
// Stage records, forwarding select encoding and the x0 index.
package hazard_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] X0 = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } stage_rec_t;

  // A producer matches a source index; x0 is never a producer.
  function automatic logic hit(
    input logic              v,
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs
  );
    return v & we & (rd != X0) & (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: operand source select for one E-stage operand.
// The M producer wins over W; a load in M never forwards.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic              use_rs_i,
  input  logic [REG_AW-1:0] rs_i,
  input  stage_rec_t        m_i,
  input  stage_rec_t        w_i,
  output fwd_sel_t          sel_o
);

  logic m_hit;
  logic w_hit;

  assign m_hit = use_rs_i & ~m_i.is_load &
    hit(m_i.valid, m_i.reg_write, m_i.rd, rs_i);
  assign w_hit = use_rs_i &
    hit(w_i.valid, w_i.reg_write, w_i.rd, rs_i);

  always_comb begin
    sel_o = FWD_REG;
    if (m_hit) begin
      sel_o = FWD_M;
    end else if (w_hit) begin
      sel_o = FWD_W;
    end
  end

  logic unused_rec;
  assign unused_rec = ^{m_i.rs1, m_i.rs2,
    m_i.use_rs1, m_i.use_rs2, w_i.rs1, w_i.rs2,
    w_i.use_rs1, w_i.use_rs2, w_i.is_load};

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_AW
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_valid,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] d_rs2,
  input  logic                      d_use_rs1,
  input  logic                      d_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] d_rd,
  input  logic                      d_reg_write,
  input  logic                      d_is_load,
  input  logic                      e_redirect,
  input  logic                      mem_busy,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      stall_all,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      fwd_d_a,
  output logic                      fwd_d_b
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0]    perf_stall_cnt
  , output logic [CNT_WIDTH-1:0]    perf_flush_cnt
  , output logic [CNT_WIDTH-1:0]    perf_busy_cnt
`endif
);

  stage_rec_t d_rec;
  stage_rec_t e_q, e_d;
  stage_rec_t m_q, m_d;
  stage_rec_t w_q, w_d;
  logic       live_q;
  logic       lu;
  logic       lu_stall;
  logic       rd_flush;
  fwd_sel_t   sel_a;
  fwd_sel_t   sel_b;

  always_comb begin
    d_rec           = '0;
    d_rec.valid     = d_valid;
    d_rec.rs1       = d_rs1;
    d_rec.rs2       = d_rs2;
    d_rec.use_rs1   = d_use_rs1;
    d_rec.use_rs2   = d_use_rs2;
    d_rec.rd        = d_rd;
    d_rec.reg_write = d_reg_write;
    d_rec.is_load   = d_is_load;
  end

  assign lu = d_valid & e_q.is_load & (
    (d_use_rs1 & hit(e_q.valid, e_q.reg_write, e_q.rd, d_rs1)) |
    (d_use_rs2 & hit(e_q.valid, e_q.reg_write, e_q.rd, d_rs2)));

  // live_q masks control for the reset cycle and the one after it.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    stall_all = 1'b0;
    if (live_q) begin
      if (mem_busy) begin
        stall_all = 1'b1;
        stall_f   = 1'b1;
        stall_d   = 1'b1;
      end else if (e_redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign rd_flush = live_q & ~mem_busy & e_redirect;
  assign lu_stall = live_q & ~mem_busy & ~e_redirect & lu;

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!stall_all) begin
      w_d         = m_q;
      m_d         = e_q;
      m_d.rs1     = X0;
      m_d.rs2     = X0;
      m_d.use_rs1 = 1'b0;
      m_d.use_rs2 = 1'b0;
      if (flush_e) begin
        e_d = '0;
      end else begin
        e_d = d_rec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      live_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      live_q <= 1'b1;
    end
  end

  fwd_unit u_fwd_a (
    .use_rs_i (e_q.use_rs1),
    .rs_i     (e_q.rs1),
    .m_i      (m_q),
    .w_i      (w_q),
    .sel_o    (sel_a)
  );

  fwd_unit u_fwd_b (
    .use_rs_i (e_q.use_rs2),
    .rs_i     (e_q.rs2),
    .m_i      (m_q),
    .w_i      (w_q),
    .sel_o    (sel_b)
  );

  assign fwd_a = sel_a;
  assign fwd_b = sel_b;

  // W writes the regfile in the same cycle D reads it.
  assign fwd_d_a = d_use_rs1 &
    hit(w_q.valid, w_q.reg_write, w_q.rd, d_rs1);
  assign fwd_d_b = d_use_rs2 &
    hit(w_q.valid, w_q.reg_write, w_q.rd, d_rs2);

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] st_q;
  logic [CNT_WIDTH-1:0] fl_q;
  logic [CNT_WIDTH-1:0] bz_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] c,
    input logic                 en
  );
    return (en && (c != '1)) ? c + ONE : c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= '0;
      fl_q <= '0;
      bz_q <= '0;
    end else begin
      st_q <= sat_inc(st_q, lu_stall);
      fl_q <= sat_inc(fl_q, rd_flush);
      bz_q <= sat_inc(bz_q, stall_all);
    end
  end

  assign perf_stall_cnt = st_q;
  assign perf_flush_cnt = fl_q;
  assign perf_busy_cnt  = bz_q;
`else
  logic unused_perf;
  assign unused_perf = lu_stall ^ rd_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table, directed sequences and a random
// run against an in-bench pipeline model of hazard_ctrl.
module tb_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs1 = '0;
  logic [4:0] d_rs2 = '0;
  logic       d_use_rs1 = 1'b0;
  logic       d_use_rs2 = 1'b0;
  logic [4:0] d_rd = '0;
  logic       d_reg_write = 1'b0;
  logic       d_is_load = 1'b0;
  logic       e_redirect = 1'b0;
  logic       mem_busy = 1'b0;
  logic       stall_f, stall_d, flush_d, flush_e, stall_all;
  logic [1:0] fwd_a, fwd_b;
  logic       fwd_d_a, fwd_d_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] perf_stall_cnt, perf_flush_cnt, perf_busy_cnt;
`endif

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  hazard_ctrl #(.CNT_WIDTH(CW)) dut (
`else
  hazard_ctrl dut (
`endif
    .clk(clk), .rst(rst), .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_rd(d_rd), .d_reg_write(d_reg_write),
    .d_is_load(d_is_load), .e_redirect(e_redirect),
    .mem_busy(mem_busy), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .stall_all(stall_all),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_d_a(fwd_d_a), .fwd_d_b(fwd_d_b)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
    , .perf_flush_cnt(perf_flush_cnt)
    , .perf_busy_cnt(perf_busy_cnt)
`endif
  );

  typedef struct packed {
    logic       dv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       redir;
    logic       busy;
  } din_t;

  typedef struct packed {
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
    logic       sa;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       fda;
    logic       fdb;
  } out_t;

  typedef struct {
    din_t d;
    out_t o;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       wr;
    logic       ld;
  } ins_t;

  vec_t tv[$];
  ins_t pipe[3];   // 0 = E, 1 = M, 2 = W
  bit   live = 1'b0;
  int   cnt_st = 0, cnt_fl = 0, cnt_bz = 0;
  int   n_chk = 0, n_pass = 0;

  function automatic din_t op(int rd, int rs1, int rs2);
    din_t d;
    d = '0;
    d.dv = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1; d.wr = 1'b1;
    d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    return d;
  endfunction

  function automatic din_t ld_op(int rd, int rs1);
    din_t d;
    d = '0;
    d.dv = 1'b1; d.u1 = 1'b1; d.wr = 1'b1; d.ld = 1'b1;
    d.rd = 5'(rd); d.rs1 = 5'(rs1);
    return d;
  endfunction

  function automatic din_t nop();
    din_t d;
    d = '0;
    return d;
  endfunction

  function automatic din_t ctl(din_t d, bit r, bit b);
    din_t x;
    x = d;
    x.redir = r;
    x.busy = b;
    return x;
  endfunction

  function automatic out_t ex(bit sf, bit sd, bit fd, bit fe,
      bit sa, bit [1:0] fa, bit [1:0] fb, bit fda, bit fdb);
    out_t o;
    o = {sf, sd, fd, fe, sa, fa, fb, fda, fdb};
    return o;
  endfunction

  function automatic din_t rand_din();
    din_t d;
    d.dv    = ($urandom_range(3) != 0);
    d.rs1   = 5'($urandom_range(3));
    d.rs2   = 5'($urandom_range(3));
    d.u1    = 1'($urandom_range(1));
    d.u2    = 1'($urandom_range(1));
    d.rd    = 5'($urandom_range(3));
    d.wr    = 1'($urandom_range(1));
    d.ld    = ($urandom_range(2) == 0);
    d.redir = ($urandom_range(7) == 0);
    d.busy  = ($urandom_range(5) == 0);
    return d;
  endfunction

  // ---- reference model ----
  function automatic bit writes(ins_t p, logic [4:0] r);
    return p.v && p.wr && (p.rd != 0) && (p.rd == r);
  endfunction

  function automatic bit load_use(din_t d);
    if (!d.dv || !pipe[0].ld) return 1'b0;
    return (d.u1 && writes(pipe[0], d.rs1)) ||
           (d.u2 && writes(pipe[0], d.rs2));
  endfunction

  function automatic logic [1:0] src(bit u, logic [4:0] r);
    logic [1:0] s;
    s = 2'd0;
    if (!u) return s;
    if (writes(pipe[2], r)) s = 2'd1;
    if (writes(pipe[1], r) && !pipe[1].ld) s = 2'd2;
    return s;
  endfunction

  function automatic out_t model_out(din_t d);
    out_t o;
    o = '0;
    if (live) begin
      if (d.busy) {o.sf, o.sd, o.sa} = 3'b111;
      else if (d.redir) {o.fd, o.fe} = 2'b11;
      else if (load_use(d)) {o.sf, o.sd, o.fe} = 3'b111;
    end
    o.fa  = src(pipe[0].u1, pipe[0].rs1);
    o.fb  = src(pipe[0].u2, pipe[0].rs2);
    o.fda = d.u1 && writes(pipe[2], d.rs1);
    o.fdb = d.u2 && writes(pipe[2], d.rs2);
    return o;
  endfunction

  task automatic model_step(din_t d);
    out_t o;
    ins_t n;
    o = model_out(d);
    if (live) begin
      if (d.busy) cnt_bz = (cnt_bz < SAT) ? cnt_bz + 1 : cnt_bz;
      else if (d.redir) cnt_fl = (cnt_fl < SAT) ? cnt_fl + 1 : cnt_fl;
      else if (load_use(d)) cnt_st = (cnt_st < SAT) ? cnt_st + 1 : cnt_st;
    end
    if (!o.sa) begin
      n = {d.dv, d.rd, d.rs1, d.rs2, d.u1, d.u2, d.wr, d.ld};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = o.fe ? '0 : n;
    end
    live = 1'b1;
  endtask

  // ---- checking ----
  function automatic void chk(string nm, logic [31:0] g, logic [31:0] e);
    n_chk++;
    if (g !== e)
      $display("FAIL %s: got %h want %h", nm, g, e);
    else
      n_pass++;
  endfunction

  function automatic out_t got();
    out_t g;
    g = {stall_f, stall_d, flush_d, flush_e, stall_all,
         fwd_a, fwd_b, fwd_d_a, fwd_d_b};
    return g;
  endfunction

  task automatic drive(din_t d);
    d_valid = d.dv; d_rs1 = d.rs1; d_rs2 = d.rs2;
    d_use_rs1 = d.u1; d_use_rs2 = d.u2; d_rd = d.rd;
    d_reg_write = d.wr; d_is_load = d.ld;
    e_redirect = d.redir; mem_busy = d.busy;
  endtask

  task automatic cyc(din_t d, out_t want, bit use_model, string tag);
    out_t e;
    @(negedge clk);
    rst = 1'b1;
    drive(d);
    #1;
    e = use_model ? model_out(d) : want;
    chk(tag, 32'(got()), 32'(e));
    @(posedge clk);
    model_step(d);
  endtask

  task automatic hold_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(rand_din());
      #1;
      chk("reset_outputs", 32'(got()), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk("reset_perf", 32'({perf_stall_cnt, perf_flush_cnt,
        perf_busy_cnt}), 32'd0);
`endif
    end
    foreach (pipe[j]) pipe[j] = '0;
    live = 1'b0;
    cnt_st = 0; cnt_fl = 0; cnt_bz = 0;
  endtask

  task automatic chk_perf(string tag);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_stall"}, 32'(perf_stall_cnt), 32'(cnt_st));
    chk({tag, "_flush"}, 32'(perf_flush_cnt), 32'(cnt_fl));
    chk({tag, "_busy"},  32'(perf_busy_cnt),  32'(cnt_bz));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  function automatic void add(din_t d, out_t o);
    vec_t v;
    v.d = d;
    v.o = o;
    tv.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t z;
    z = '0;
    // release cycle: control masked even with busy/redirect
    add(ctl(nop(), 1, 1), z);
    // back-to-back RAW: M forward
    add(op(5, 1, 2), z);
    add(op(6, 5, 1), z);
    add(nop(), ex(0,0,0,0,0,2,0,0,0));
    add(nop(), z);
    // one nop gap: W forward
    add(op(5, 1, 2), z);
    add(nop(), z);
    add(op(6, 5, 1), z);
    add(nop(), ex(0,0,0,0,0,1,0,0,0));
    add(nop(), z);
    // decode bypass of W write data
    add(op(10, 0, 6), ex(0,0,0,0,0,0,0,0,1));
    // x0 destination never forwards
    add(op(0, 1, 0), z);
    add(op(11, 0, 3), z);
    add(nop(), z);
    add(op(12, 0, 0), z);
    // load-use: one bubble then W forward
    add(ld_op(7, 1), z);
    add(op(8, 7, 2), ex(1,1,0,1,0,0,0,0,0));
    add(op(8, 7, 2), z);
    add(nop(), ex(0,0,0,0,0,1,0,0,0));
    // redirect overrides load-use
    add(ld_op(9, 2), z);
    add(ctl(op(3, 9, 9), 1, 0), ex(0,0,1,1,0,0,0,0,0));
    add(nop(), z);
    // mem_busy with dependent pair in E/M
    add(op(13, 1, 2), z);
    add(op(14, 13, 13), z);
    add(ctl(nop(), 0, 1), ex(1,1,0,0,1,2,2,0,0));
    add(ctl(nop(), 1, 1), ex(1,1,0,0,1,2,2,0,0));
    add(ctl(nop(), 0, 1), ex(1,1,0,0,1,2,2,0,0));
    add(ctl(nop(), 1, 0), ex(0,0,1,1,0,2,2,0,0));
    add(op(16, 13, 14), ex(0,0,0,0,0,0,0,1,0));
    add(nop(), ex(0,0,0,0,0,0,1,0,0));

    hold_reset(3);
    foreach (tv[i]) cyc(tv[i].d, tv[i].o, 1'b0, $sformatf("vec%0d", i));

    for (int k = 0; k < 20; k++) begin
      cyc(ld_op(7, 1), z, 1'b1, "lu_load");
      cyc(op(8, 7, 2), z, 1'b1, "lu_stall");
      cyc(op(8, 7, 2), z, 1'b1, "lu_replay");
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_saturated", 32'(perf_stall_cnt), 32'(SAT));
`endif
    chk_perf("perf_after_lu");

    repeat (400) cyc(rand_din(), z, 1'b1, "random");
    chk_perf("perf_after_random");

    hold_reset(2);
    repeat (30) cyc(rand_din(), z, 1'b1, "post_reset");
    chk_perf("perf_post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
